// File: rtl/win_accum.sv
// win_accum: multi-channel windowed accumulator.
// Each channel keeps its own running sum and sample count. When a channel
// reaches WIN_LEN accepted samples, its window sum goes into a one-entry
// output slot and the channel restarts from zero.
//
// Optional feature: define WIN_ACCUM_SATURATE_EN to make additions saturate
// at 2^ACC_W-1 and to set the sticky per-channel ovf flags. Without it, sums
// wrap modulo 2^ACC_W and ovf is tied to 0.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   clr                 sync clear of all channel sums/counts and ovf
//   in_valid/in_ready   sample handshake (in_ready is combinational)
//   in_ch, in_val       target channel and sample value
//   set_val             load in_val instead of adding (fresh window)
//   out_valid/out_ready window sum handshake
//   out_ch, out_sum     channel and sum of the emitted window
//   acc_flat            running sums, channel k at [k*ACC_W +: ACC_W]
//   err                 one-cycle pulse after an out-of-range sample
//   ovf                 per-channel sticky overflow
module win_accum #(
    parameter int unsigned IN_W    = 32,
    parameter int unsigned ACC_W   = 64,
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned WIN_LEN = 16,
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CH_W-1:0]          in_ch,
    input  logic [IN_W-1:0]          in_val,
    input  logic                     set_val,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CH_W-1:0]          out_ch,
    output logic [ACC_W-1:0]         out_sum,
    output logic [NUM_CH*ACC_W-1:0]  acc_flat,
    output logic                     err,
    output logic [NUM_CH-1:0]        ovf
);

    localparam int unsigned CNT_W = $clog2(WIN_LEN + 1);
    localparam logic [CNT_W-1:0] WIN_CNT = CNT_W'(WIN_LEN);
    localparam bit CH_POW2 = ((1 << CH_W) == NUM_CH);
`ifdef WIN_ACCUM_SATURATE_EN
    localparam int unsigned EXT_W = ACC_W + 1;
`endif

    typedef enum logic {S_EMPTY, S_FULL} slot_state_e;

    slot_state_e        state_q, state_d;
    logic [ACC_W-1:0]   sum_q [NUM_CH];
    logic [ACC_W-1:0]   sum_d [NUM_CH];
    logic [CNT_W-1:0]   cnt_q [NUM_CH];
    logic [CNT_W-1:0]   cnt_d [NUM_CH];
    logic [CH_W-1:0]    out_ch_q, out_ch_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic               err_q, err_d;

    logic               accept_c;
    logic               in_range_c;
    logic               close_c;
    logic [ACC_W-1:0]   close_sum_c;
    logic [ACC_W-1:0]   nxt_sum_c;
    logic [CNT_W-1:0]   nxt_cnt_c;
`ifdef WIN_ACCUM_SATURATE_EN
    logic [NUM_CH-1:0]  ovf_q, ovf_d;
    logic [EXT_W-1:0]   add_ext_c;
`endif

    // Channel range check only matters when NUM_CH is not a power of two.
    generate
        if (CH_POW2) begin : g_range_full
            assign in_range_c = 1'b1;
        end else begin : g_range_chk
            assign in_range_c = (32'(in_ch) < NUM_CH);
        end
    endgenerate

    assign out_valid = (state_q == S_FULL);
    assign in_ready  = !clr && (!out_valid || out_ready);
    assign accept_c  = in_valid && in_ready;

    // Per-channel sum/count update and window-close detection.
    always_comb begin
        close_c     = 1'b0;
        close_sum_c = '0;
        nxt_sum_c   = '0;
        nxt_cnt_c   = '0;
        err_d       = accept_c && !in_range_c;
`ifdef WIN_ACCUM_SATURATE_EN
        ovf_d       = ovf_q;
        add_ext_c   = '0;
`endif
        for (int k = 0; k < NUM_CH; k++) begin
            sum_d[k] = sum_q[k];
            cnt_d[k] = cnt_q[k];
            if (clr) begin
                sum_d[k] = '0;
                cnt_d[k] = '0;
`ifdef WIN_ACCUM_SATURATE_EN
                ovf_d[k] = 1'b0;
`endif
            end else if (accept_c && in_range_c && (in_ch == CH_W'(k))) begin
                if (set_val) begin
                    nxt_sum_c = ACC_W'(in_val);
                    nxt_cnt_c = CNT_W'(1);
                end else begin
`ifdef WIN_ACCUM_SATURATE_EN
                    add_ext_c = {1'b0, sum_q[k]} + EXT_W'(in_val);
                    if (add_ext_c[ACC_W]) begin
                        nxt_sum_c = '1;
                        ovf_d[k]  = 1'b1;
                    end else begin
                        nxt_sum_c = add_ext_c[ACC_W-1:0];
                    end
`else
                    nxt_sum_c = sum_q[k] + ACC_W'(in_val);
`endif
                    nxt_cnt_c = cnt_q[k] + CNT_W'(1);
                end
                if (nxt_cnt_c == WIN_CNT) begin
                    close_c     = 1'b1;
                    close_sum_c = nxt_sum_c;
                    sum_d[k]    = '0;
                    cnt_d[k]    = '0;
`ifdef WIN_ACCUM_SATURATE_EN
                    ovf_d[k]    = 1'b0;
`endif
                end else begin
                    sum_d[k] = nxt_sum_c;
                    cnt_d[k] = nxt_cnt_c;
                end
            end
        end
    end

    // Output slot: a close always loads; a full slot empties on out_ready.
    always_comb begin
        state_d   = state_q;
        out_ch_d  = out_ch_q;
        out_sum_d = out_sum_q;
        case (state_q)
            S_EMPTY: begin
                if (close_c) begin
                    state_d   = S_FULL;
                    out_ch_d  = in_ch;
                    out_sum_d = close_sum_c;
                end
            end
            S_FULL: begin
                if (close_c) begin
                    out_ch_d  = in_ch;
                    out_sum_d = close_sum_c;
                end else if (out_ready) begin
                    state_d = S_EMPTY;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_EMPTY;
            out_ch_q  <= '0;
            out_sum_q <= '0;
            err_q     <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                sum_q[k] <= '0;
                cnt_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            out_ch_q  <= out_ch_d;
            out_sum_q <= out_sum_d;
            err_q     <= err_d;
            for (int k = 0; k < NUM_CH; k++) begin
                sum_q[k] <= sum_d[k];
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

`ifdef WIN_ACCUM_SATURATE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
    assign ovf = ovf_q;
`else
    assign ovf = '0;
`endif

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
            assign acc_flat[g*ACC_W +: ACC_W] = sum_q[g];
        end
    endgenerate

    assign out_ch  = out_ch_q;
    assign out_sum = out_sum_q;
    assign err     = err_q;

endmodule

// File: doc/win_accum.md
Name: win_accum

Overview:
Parametrised multi-channel windowed accumulator; the next generation of the single-channel 32-in/64-out accumulator.
- Keeps an independent running sum per channel.
- Accepts tagged samples through a valid/ready handshake.
- After WIN_LEN samples on a channel, emits that channel's window sum through a one-entry valid/ready output slot, then restarts the channel.
- Sits between sample producers and downstream statistics logic.

Parameters:
IN_W, 32, sample width (unsigned)
ACC_W, 64, accumulator and output sum width; must be >= IN_W
NUM_CH, 4, number of independent channels; >= 1
WIN_LEN, 16, samples per window; >= 1
CH_W, $clog2(NUM_CH) min 1, channel index width (localparam)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear of all channel sums and counts
in_valid  input  1  sample valid
in_ready  output  1  sample accepted when in_valid && in_ready
in_ch  input  CH_W  target channel
in_val  input  IN_W  sample value
set_val  input  1  load in_val instead of adding (starts a fresh window)
out_valid  output  1  window sum available
out_ready  input  1  consumer accepts the window sum
out_ch  output  CH_W  channel of the emitted sum
out_sum  output  ACC_W  emitted window sum
acc_flat  output  NUM_CH*ACC_W  running sums; channel k at bits [k*ACC_W +: ACC_W]
err  output  1  one-cycle pulse: an accepted sample had in_ch >= NUM_CH
ovf  output  NUM_CH  per-channel sticky overflow (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): all sums, counts, out_valid, out_ch, out_sum, err and ovf = 0. acc_flat = 0.
- Output slot is a two-state FSM.
  - EMPTY (out_valid=0) -> FULL on window close.
  - FULL -> EMPTY on out_ready, unless a new window closes in the same cycle; the slot then stays FULL with the new data.
- in_ready = !clr && (!out_valid || out_ready). This is combinational from out_valid, out_ready and clr; there is no combinational path from in_valid.
- Accept rule, applied with 1-cycle latency (registered):
  - set_val=1: sum[ch] <= zero-extended in_val; cnt[ch] <= 1.
  - set_val=0: sum[ch] <= sum[ch] + zext(in_val), modulo 2^ACC_W; cnt[ch] <= cnt[ch] + 1.
- Window close: when the new cnt equals WIN_LEN:
  - out_sum <= new sum; out_ch <= ch; out_valid <= 1.
  - sum[ch] <= 0 and cnt[ch] <= 0 in the same edge.
  - acc_flat shows 0 for that channel from the next cycle.
- WIN_LEN=1: every accepted sample closes a window; the emitted sum equals in_val (set_val is irrelevant).
- out_valid, out_ch and out_sum stay stable while out_valid && !out_ready.
- Out-of-range channel (in_ch >= NUM_CH, only possible when NUM_CH is not a power of 2): sample accepted and discarded; err=1 in the next cycle; no state changes.
- clr=1: all sums and counts become 0 next cycle; ovf becomes 0. The output slot is not affected and may still drain. in_ready=0, so no sample is accepted that cycle.
- Reset mid-window discards all partial sums; a pending output is lost.
- Channels are fully independent; interleaved samples do not affect other channels' counts.

Optional Feature:
Macro WIN_ACCUM_SATURATE_EN.
- Defined:
  - An addition whose true result exceeds 2^ACC_W-1 stores 2^ACC_W-1.
  - ovf[ch] sets and stays set until clr, a window close on that channel, or reset.
  - The emitted out_sum is the saturated value.
- Undefined: sums wrap modulo 2^ACC_W; ovf is tied to 0.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> out_valid=0, acc_flat=0, ovf=0; rst_n=1 at t=10 -> in_ready=1.
- Window close: WIN_LEN=4, ch0 samples 10,20,30,40 -> acc_flat[ch0] = 10, 30, 60, then 0; single out_valid with out_ch=0 and out_sum=100.
- Interleaving and load: ch1 gets 5, ch2 gets 7, then ch1 gets set_val with 3 -> ch1=3 (cnt 1), ch2=7; no output.
- Backpressure: out_ready=0 with a pending window, then a second channel completes -> in_ready=0, second close stalls, first out_sum held; out_ready=1 -> both drain in order.
- Overflow: ACC_W=IN_W=8, add 200 then 100.
  - Without the macro: sum=44, ovf=0.
  - With WIN_ACCUM_SATURATE_EN: sum=255, ovf[ch]=1.
- clr mid-window plus out-of-range: clr after 2 samples -> sums 0, then 4 more samples close the window; NUM_CH=3 with in_ch=3 -> err pulse, no state change.
